wait_merge_seq: RTL

Clocked sequencer that exercises and shares one two-way click merge stage (drive0/drive1 in, driveNext out, freeNext back). It issues the two branch drive pulses with a programmable order and skew, and waits for the merged drive. It then returns freeNext, collects both branch frees, and repeats for a programmed number of rounds. It sits on the FPGA control side as the bring-up and characterisation master for the merge, and reports round count, per-round latency and protocol errors.

---
 rtl/wait_merge_pkg.sv | 28 ++
 rtl/sync_rise.sv | 30 +++
 rtl/wait_merge_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/wait_merge_pkg.sv
// Shared types and constants for the wait_merge_seq merge-stage sequencer.
// Holds the FSM state encoding, the error codes reported on o_err_code and
// the default parameter values used by the top level.
package wait_merge_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_SKEW_W      = 8;
  localparam int DEF_TO_W        = 16;
  localparam int DEF_CNT_W       = 32;
  localparam int ROUNDS_W        = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_SKEW,
    S_WAIT_MERGE,
    S_FREE,
    S_WAIT_FREE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MERGE_TO = 2'b01;
  localparam logic [1:0] ERR_FREE_TO  = 2'b10;
  localparam logic [1:0] ERR_SPURIOUS = 2'b11;

endpackage

// File: rtl/sync_rise.sv
// Multi-flop synchroniser followed by a registered rising-edge detector.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   d        : asynchronous input
//   rise     : one-cycle pulse, STAGES+1 cycles after d rises
module sync_rise #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      last <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      last <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~last;
    end
  end

endmodule

// File: rtl/wait_merge_seq.sv
// Bring-up / characterisation master for a two-way click merge stage.
// Fires drive0/drive1 with programmable order and skew, waits for the merged
// driveNext, returns freeNext, collects both branch frees, and repeats.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   i_start                  : start pulse (accepted when not busy)
//   i_rounds/i_order/i_skew/i_timeout : run configuration, latched on start
//   o_drive0/o_drive1        : branch drive pulses to the merge
//   i_driveNext              : merged drive from the merge (async)
//   o_freeNext               : free pulse to the merge
//   i_free0/i_free1          : branch frees from the merge (async)
//   o_busy/o_done/o_err/o_err_code : status
//   o_round_cnt/o_lat        : completed rounds and last round latency
//
// state        | meaning
// S_IDLE       | waiting for i_start
// S_FIRE       | first drive (both when skew = 0)
// S_SKEW       | counting down to the second drive
// S_WAIT_MERGE | waiting for driveNext, latency/timeout counting
// S_FREE       | freeNext pulse, round counted
// S_WAIT_FREE  | collecting free0/free1, timeout counting
// S_DONE       | o_done pulse
// S_ERR        | error latched, sequence aborted
module wait_merge_seq
  import wait_merge_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int SKEW_W      = DEF_SKEW_W,
  parameter int TO_W        = DEF_TO_W,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [ROUNDS_W-1:0] i_rounds,
  input  logic                i_order,
  input  logic [SKEW_W-1:0]   i_skew,
  input  logic [TO_W-1:0]     i_timeout,
  output logic                o_drive0,
  output logic                o_drive1,
  input  logic                i_driveNext,
  output logic                o_freeNext,
  input  logic                i_free0,
  input  logic                i_free1,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [1:0]          o_err_code,
  output logic [CNT_W-1:0]    o_round_cnt,
  output logic [TO_W-1:0]     o_lat
);

  logic dn_rise, f0_rise, f1_rise;

  sync_rise #(.STAGES(SYNC_STAGES)) u_sync_dn (.clk(clk), .rst(rst), .d(i_driveNext), .rise(dn_rise));
  sync_rise #(.STAGES(SYNC_STAGES)) u_sync_f0 (.clk(clk), .rst(rst), .d(i_free0),     .rise(f0_rise));
  sync_rise #(.STAGES(SYNC_STAGES)) u_sync_f1 (.clk(clk), .rst(rst), .d(i_free1),     .rise(f1_rise));

  state_t              state, state_nxt;
  logic [SKEW_W-1:0]   skew_cnt, skew_cnt_nxt, skew_q, skew_q_nxt;
  logic                order_q, order_q_nxt;
  logic [TO_W-1:0]     timeout_q, timeout_q_nxt, cnt, cnt_nxt, cnt_inc;
  logic [ROUNDS_W-1:0] rounds_q, rounds_q_nxt, rounds_left, rounds_left_nxt;
  logic                f0_seen, f0_seen_nxt, f1_seen, f1_seen_nxt;
  logic                drive0_nxt, drive1_nxt, free_nxt, busy_nxt, done_nxt, err_nxt;
  logic [1:0]          err_code_nxt;
  logic [CNT_W-1:0]    round_cnt_nxt;
  logic [TO_W-1:0]     lat_nxt;
  logic                timed_out, first_hit, second_hit;

  always_comb begin
    state_nxt       = state;
    skew_cnt_nxt    = skew_cnt;
    cnt_nxt         = cnt;
    order_q_nxt     = order_q;
    skew_q_nxt      = skew_q;
    timeout_q_nxt   = timeout_q;
    rounds_q_nxt    = rounds_q;
    rounds_left_nxt = rounds_left;
    f0_seen_nxt     = f0_seen;
    f1_seen_nxt     = f1_seen;
    err_nxt         = o_err;
    err_code_nxt    = o_err_code;
    round_cnt_nxt   = o_round_cnt;
    lat_nxt         = o_lat;
    // Latency counter saturates; the timeout fires on the cycle the counter
    // would reach the programmed limit.
    cnt_inc   = (&cnt) ? cnt : cnt + TO_W'(1);
    timed_out = (timeout_q != '0) && (cnt_inc >= timeout_q);

    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        state_nxt = S_IDLE;
        if (i_start) begin
          order_q_nxt     = i_order;
          skew_q_nxt      = i_skew;
          timeout_q_nxt   = i_timeout;
          rounds_q_nxt    = i_rounds;
          rounds_left_nxt = i_rounds;
          err_nxt         = 1'b0;
          err_code_nxt    = ERR_NONE;
          round_cnt_nxt   = '0;
          state_nxt       = S_FIRE;
        end
      end
      S_FIRE: begin
        if (dn_rise) begin
          state_nxt    = S_ERR;
          err_code_nxt = ERR_SPURIOUS;
        end else if (skew_q == '0) begin
          state_nxt = S_WAIT_MERGE;
          cnt_nxt   = TO_W'(1);
        end else begin
          state_nxt    = S_SKEW;
          skew_cnt_nxt = skew_q - SKEW_W'(1);
        end
      end
      S_SKEW: begin
        if (dn_rise) begin
          state_nxt    = S_ERR;
          err_code_nxt = ERR_SPURIOUS;
        end else if (skew_cnt == '0) begin
          state_nxt = S_WAIT_MERGE;
          cnt_nxt   = TO_W'(1);
        end else begin
          skew_cnt_nxt = skew_cnt - SKEW_W'(1);
        end
      end
      S_WAIT_MERGE: begin
        cnt_nxt = cnt_inc;
        if (dn_rise) begin
          state_nxt     = S_FREE;
          lat_nxt       = cnt;
          round_cnt_nxt = o_round_cnt + CNT_W'(1);
          f0_seen_nxt   = 1'b0;
          f1_seen_nxt   = 1'b0;
          if (rounds_left != '0) rounds_left_nxt = rounds_left - ROUNDS_W'(1);
        end else if (timed_out) begin
          state_nxt    = S_ERR;
          err_code_nxt = ERR_MERGE_TO;
        end
      end
      S_FREE: begin
        state_nxt   = S_WAIT_FREE;
        cnt_nxt     = TO_W'(1);
        f0_seen_nxt = f0_seen | f0_rise;
        f1_seen_nxt = f1_seen | f1_rise;
      end
      S_WAIT_FREE: begin
        cnt_nxt     = cnt_inc;
        f0_seen_nxt = f0_seen | f0_rise;
        f1_seen_nxt = f1_seen | f1_rise;
        if (f0_seen_nxt && f1_seen_nxt) begin
          state_nxt = ((rounds_q == '0) || (rounds_left != '0)) ? S_FIRE : S_DONE;
        end else if (timed_out) begin
          state_nxt    = S_ERR;
          err_code_nxt = ERR_FREE_TO;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (state_nxt == S_ERR) err_nxt = 1'b1;

    // Outputs are registered, so pulses are decided from the next state.
    first_hit  = (state_nxt == S_FIRE);
    second_hit = ((state_nxt == S_FIRE) && (skew_q_nxt == '0)) ||
                 ((state_nxt == S_SKEW) && (skew_cnt_nxt == '0));
    drive0_nxt = order_q_nxt ? second_hit : first_hit;
    drive1_nxt = order_q_nxt ? first_hit  : second_hit;
    free_nxt   = (state_nxt == S_FREE);
    done_nxt   = (state_nxt == S_DONE);
    busy_nxt   = (state_nxt != S_IDLE) && (state_nxt != S_DONE) && (state_nxt != S_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      skew_cnt    <= '0;
      cnt         <= '0;
      order_q     <= 1'b0;
      skew_q      <= '0;
      timeout_q   <= '0;
      rounds_q    <= '0;
      rounds_left <= '0;
      f0_seen     <= 1'b0;
      f1_seen     <= 1'b0;
      o_drive0    <= 1'b0;
      o_drive1    <= 1'b0;
      o_freeNext  <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_err_code  <= ERR_NONE;
      o_round_cnt <= '0;
      o_lat       <= '0;
    end else begin
      state       <= state_nxt;
      skew_cnt    <= skew_cnt_nxt;
      cnt         <= cnt_nxt;
      order_q     <= order_q_nxt;
      skew_q      <= skew_q_nxt;
      timeout_q   <= timeout_q_nxt;
      rounds_q    <= rounds_q_nxt;
      rounds_left <= rounds_left_nxt;
      f0_seen     <= f0_seen_nxt;
      f1_seen     <= f1_seen_nxt;
      o_drive0    <= drive0_nxt;
      o_drive1    <= drive1_nxt;
      o_freeNext  <= free_nxt;
      o_busy      <= busy_nxt;
      o_done      <= done_nxt;
      o_err       <= err_nxt;
      o_err_code  <= err_code_nxt;
      o_round_cnt <= round_cnt_nxt;
      o_lat       <= lat_nxt;
    end
  end

endmodule
